// File: rtl/byte_serial_adder_if.sv
// byte_serial_adder_if: start/busy/done handshake plus operand and result bus for the byte-serial adder
interface byte_serial_adder_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: adds two NBYTES-wide operands one byte slice per clock, LSB first
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input logic               clk,
    input logic               rst,
    byte_serial_adder_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic [IW-1:0]  r_idx;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_carry;
    logic [W-1:0]   r_sum;
    logic           r_cout;
    logic           r_ovf;
    logic           r_busy;
    logic           r_done;

    logic [IW+2:0]  w_base;
    logic [7:0]     w_a8;
    logic [7:0]     w_b8;
    logic [8:0]     w_add;
    logic [7:0]     w_s8;
    logic           w_c;
    logic           w_last;
    logic           w_accept;

    // current byte slice through the combinational a+b+cin stage
    always_comb begin
        w_base   = {r_idx, 3'b000};
        w_a8     = r_a[w_base +: 8];
        w_b8     = r_b[w_base +: 8];
        w_add    = {1'b0, w_a8} + {1'b0, w_b8} + {8'd0, r_carry};
        w_s8     = w_add[7:0];
        w_c      = w_add[8];
        w_last   = (r_idx == IW'(NBYTES - 1));
        w_accept = bus.start && (r_state != RUN);
    end

    // sequencer: latch operands on start, write one sum byte per RUN cycle, pulse done after the top byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_sum[w_base +: 8] <= w_s8;
                    r_carry            <= w_c;
                    r_idx              <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_c;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s8[7] != r_a[W-1]);
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_sum   <= '0;
                        r_idx   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: directed vectors for the 4-byte serial adder
module tb_byte_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;
    int   nd;
    logic [31:0] s;

    always #5 clk = ~clk;

    byte_serial_adder_if #(.NBYTES(4)) bus ();

    byte_serial_adder #(.NBYTES(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!bus.done && cnt < 20);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic ec, input logic eo);
        int k;
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(k);
        chk({tag, "_lat"}, 32'(k), 32'd4);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        tick();
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", bus.sum, 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        // FF + 1: busy for four samples, done at the fourth edge
        bus.a = 32'h0000_00FF; bus.b = 32'h0000_0001; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t1_busy0", 32'(bus.busy), 32'd1);
        tick();
        chk("t1_busy1", 32'(bus.busy), 32'd1);
        chk("t1_part", bus.sum, 32'h0000_0000);
        tick();
        chk("t1_busy2", 32'(bus.busy), 32'd1);
        tick();
        chk("t1_busy3", 32'(bus.busy), 32'd1);
        chk("t1_nodone3", 32'(bus.done), 32'd0);
        tick();
        chk("t1_busy4", 32'(bus.busy), 32'd0);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_sum", bus.sum, 32'h0000_0100);
        chk("t1_cout", 32'(bus.cout), 32'd0);
        chk("t1_ovf", 32'(bus.ovf), 32'd0);
        tick();
        chk("t1_done_drop", 32'(bus.done), 32'd0);
        chk("t1_sum_hold", bus.sum, 32'h0000_0100);

        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("posovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("negovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // start and operand changes while busy are ignored
        bus.a = 32'h1234_5678; bus.b = 32'h1111_1111; bus.cin = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("bz_cout_hold", 32'(bus.cout), 32'd1);
        chk("bz_part", bus.sum, 32'h0000_008A);
        bus.start = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        nd = 0;
        s  = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done) begin
                nd++;
                s = bus.sum;
            end
        end
        chk("bz_ndone", 32'(nd), 32'd1);
        chk("bz_sum_at_done", s, 32'h2345_678A);
        chk("bz_sum_idle", bus.sum, 32'h2345_678A);
        chk("bz_cout", 32'(bus.cout), 32'd0);
        chk("bz_ovf", 32'(bus.ovf), 32'd0);

        // back-to-back with start held high through DONE
        bus.a = 32'd5; bus.b = 32'd6; bus.cin = 1'b0; bus.start = 1'b1;
        tick();
        wait_done(n);
        chk("b2b_lat1", 32'(n), 32'd4);
        chk("b2b_sum1", bus.sum, 32'h0000_000B);
        bus.a = 32'd1; bus.b = 32'd2;
        tick();
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done_low", 32'(bus.done), 32'd0);
        wait_done(n);
        chk("b2b_gap", 32'(n + 1), 32'd5);
        chk("b2b_sum2", bus.sum, 32'h0000_0003);

        // reset mid-operation
        tick();
        bus.a = 32'h0101_0101; bus.b = 32'h0101_0101; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("mr_part", bus.sum, 32'h0000_0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_done", 32'(bus.done), 32'd0);
        chk("mr_sum", bus.sum, 32'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("mr_no_done", 32'(nd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
